// File: rtl/stack_op_controller_pkg.sv
// Shared types and default constants for the stack operation controller.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'd0,
        OP_POP   = 2'd1,
        OP_PEEK  = 2'd2,
        OP_SPRST = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_MEM  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [15:0] DEF_STACK_BASE  = 16'hFFFE;
    localparam logic [15:0] DEF_STACK_LIMIT = 16'hF000;
    localparam logic [15:0] DEF_WORD_BYTES  = 16'd2;

endpackage

// File: rtl/stack_op_controller.sv
// Stack operation sequencer: bounds check, data-memory handshake and SP update.
//
// state | meaning
// INIT  | one cycle after reset, loads STACK_BASE into SP
// IDLE  | ready for a request; bounds checked on acceptance
// MEM   | memory strobe held until mem_ack
// DONE  | one-cycle response, SP write and error report
module stack_op_controller
    import stack_ctrl_pkg::*;
#(
    parameter int                 DATA_W      = 16,
    parameter logic [DATA_W-1:0]  STACK_BASE  = DATA_W'(DEF_STACK_BASE),
    parameter logic [DATA_W-1:0]  STACK_LIMIT = DATA_W'(DEF_STACK_LIMIT),
    parameter logic [DATA_W-1:0]  WORD_BYTES  = DATA_W'(DEF_WORD_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [1:0]        i_req_op,
    input  logic [DATA_W-1:0] i_req_data,
    input  logic [DATA_W-1:0] i_sp_in,
    output logic              o_sp_write,
    output logic [DATA_W-1:0] o_sp_next,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_mem_re,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ack,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_rsp_err,
    output logic              o_err_overflow,
    output logic              o_err_underflow
);

    localparam logic [1:0] S_INIT = ST_INIT;
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MEM  = ST_MEM;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]        r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_sp;
    logic [DATA_W-1:0] r_new_sp;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              r_ovf;
    logic              r_unf;

    logic [DATA_W:0]   w_sub;
    logic              w_push_ovf;
    logic              w_pop_unf;
    logic              w_op_err;

    // The extra MSB of the subtract is the borrow, catching SP wrap below zero.
    assign w_sub      = {1'b0, i_sp_in} - {1'b0, WORD_BYTES};
    assign w_push_ovf = w_sub[DATA_W] | (w_sub[DATA_W-1:0] < STACK_LIMIT);
    assign w_pop_unf  = (i_sp_in >= STACK_BASE);

    // Bounds check of the request being offered in IDLE.
    always_comb begin
        w_op_err = 1'b0;
        case (i_req_op)
            OP_PUSH:         w_op_err = w_push_ovf;
            OP_POP, OP_PEEK: w_op_err = w_pop_unf;
            default:         w_op_err = 1'b0;
        endcase
    end

    // State sequencing, request latching and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_op     <= '0;
            r_data   <= '0;
            r_sp     <= '0;
            r_new_sp <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: r_state <= S_IDLE;
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_op     <= i_req_op;
                        r_data   <= i_req_data;
                        r_sp     <= i_sp_in;
                        r_new_sp <= w_sub[DATA_W-1:0];
                        r_err    <= w_op_err;
                        if (i_req_op == OP_SPRST) begin
                            r_ovf   <= 1'b0;
                            r_unf   <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_op_err) begin
                            if (i_req_op == OP_PUSH) r_ovf <= 1'b1;
                            else                     r_unf <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_MEM;
                        end
                    end
                end
                S_MEM: begin
                    if (i_mem_ack) begin
                        r_rdata <= i_mem_rdata;
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Output decode from state; everything is held low while reset is asserted.
    always_comb begin
        o_req_ready = 1'b0;
        o_sp_write  = 1'b0;
        o_sp_next   = '0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_data  = '0;
        o_rsp_err   = 1'b0;
        if (!reset) begin
            case (r_state)
                S_INIT: begin
                    o_sp_write = 1'b1;
                    o_sp_next  = STACK_BASE;
                end
                S_IDLE: o_req_ready = 1'b1;
                S_MEM: begin
                    if (r_op == OP_PUSH) begin
                        o_mem_we    = 1'b1;
                        o_mem_addr  = r_new_sp;
                        o_mem_wdata = r_data;
                    end else begin
                        o_mem_re   = 1'b1;
                        o_mem_addr = r_sp;
                    end
                end
                S_DONE: begin
                    o_rsp_valid = 1'b1;
                    if (r_err) begin
                        o_rsp_err = 1'b1;
                    end else begin
                        case (r_op)
                            OP_PUSH: begin
                                o_sp_write = 1'b1;
                                o_sp_next  = r_new_sp;
                                o_rsp_data = r_data;
                            end
                            OP_POP: begin
                                o_sp_write = 1'b1;
                                o_sp_next  = r_sp + WORD_BYTES;
                                o_rsp_data = r_rdata;
                            end
                            OP_PEEK: o_rsp_data = r_rdata;
                            default: begin
                                o_sp_write = 1'b1;
                                o_sp_next  = STACK_BASE;
                                o_rsp_data = STACK_BASE;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err_overflow  = r_ovf;
    assign o_err_underflow = r_unf;

endmodule
